// File: rtl/memory_bus_arbiter_if.sv
// Bus bundle between N masters, the arbiter and one memory port.
// Handshake: a transfer happens in a cycle where Valid and Taken are both high; Valid holds with stable payload until then.
interface memory_bus_arbiter_if #(
  parameter int NUM_MASTERS   = 4,
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4
);
  logic [NUM_MASTERS-1:0]                    mMsValid;
  logic [NUM_MASTERS-1:0]                    mMsTaken;
  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0] mMsAddress;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    mMsData;
  logic [NUM_MASTERS-1:0]                    mMsWrite;
  logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]      mMsID;

  logic                     msValid;
  logic                     msTaken;
  logic [ADDRESS_WIDTH-1:0] msAddress;
  logic [DATA_WIDTH-1:0]    msData;
  logic                     msWrite;
  logic [ID_WIDTH-1:0]      msID;

  logic                  smValid;
  logic                  smTaken;
  logic [DATA_WIDTH-1:0] smData;
  logic [ID_WIDTH-1:0]   smID;

  logic                   mSmValid;
  logic [DATA_WIDTH-1:0]  mSmData;
  logic [ID_WIDTH-1:0]    mSmID;
  logic [NUM_MASTERS-1:0] mSmTaken;

  // Arbiter view.
  modport slave (
    input  mMsValid, mMsAddress, mMsData, mMsWrite, mMsID,
    output mMsTaken,
    output msValid, msAddress, msData, msWrite, msID,
    input  msTaken,
    input  smValid, smData, smID,
    output smTaken,
    output mSmValid, mSmData, mSmID,
    input  mSmTaken
  );

  // Environment view (masters plus memory).
  modport master (
    output mMsValid, mMsAddress, mMsData, mMsWrite, mMsID,
    input  mMsTaken,
    input  msValid, msAddress, msData, msWrite, msID,
    output msTaken,
    output smValid, smData, smID,
    input  smTaken,
    input  mSmValid, mSmData, mSmID,
    output mSmTaken
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter of N masters onto one memory request slot, plus a
// single-entry response buffer broadcasting memory responses back to all masters.
module memory_bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int DATA_WIDTH    = 24,
  parameter int ADDRESS_WIDTH = 32,
  parameter int ID_WIDTH      = 4
) (
  input logic                  clock,
  input logic                  reset,
  memory_bus_arbiter_if.slave  bus
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic                     ms_valid_q;
  logic [ADDRESS_WIDTH-1:0] ms_address_q;
  logic [DATA_WIDTH-1:0]    ms_data_q;
  logic                     ms_write_q;
  logic [ID_WIDTH-1:0]      ms_id_q;
  logic [GW-1:0]            last_grant_q;

  logic                  msm_valid_q;
  logic [DATA_WIDTH-1:0] msm_data_q;
  logic [ID_WIDTH-1:0]   msm_id_q;

  logic                   load_en;
  logic                   grant_valid;
  logic [GW-1:0]          grant_idx;
  logic [GW-1:0]          cand;
  logic [NUM_MASTERS-1:0] taken_d;
  logic                   resp_drain;
  logic                   resp_accept;

  assign load_en = !ms_valid_q || bus.msTaken;

  // Search starts one past the last winner so every master gets a turn.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant_q;
    cand        = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = GW'((int'(last_grant_q) + i) % NUM_MASTERS);
      if (!grant_valid && bus.mMsValid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    taken_d = '0;
    if (!reset && load_en && grant_valid) taken_d[grant_idx] = 1'b1;
  end

  assign bus.mMsTaken = taken_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      ms_address_q <= '0;
      ms_data_q    <= '0;
      ms_write_q   <= 1'b0;
      ms_id_q      <= '0;
      last_grant_q <= GW'(NUM_MASTERS - 1);
    end else if (load_en) begin
      if (grant_valid) begin
        ms_valid_q   <= 1'b1;
        ms_address_q <= bus.mMsAddress[grant_idx];
        ms_data_q    <= bus.mMsData[grant_idx];
        ms_write_q   <= bus.mMsWrite[grant_idx];
        ms_id_q      <= bus.mMsID[grant_idx];
        last_grant_q <= grant_idx;
      end else begin
        ms_valid_q <= 1'b0;
      end
    end
  end

  assign bus.msValid   = ms_valid_q;
  assign bus.msAddress = ms_address_q;
  assign bus.msData    = ms_data_q;
  assign bus.msWrite   = ms_write_q;
  assign bus.msID      = ms_id_q;

  // Several mSmTaken bits at once still count as one drain.
  assign resp_drain  = msm_valid_q && (|bus.mSmTaken);
  assign resp_accept = !reset && bus.smValid && (!msm_valid_q || resp_drain);
  assign bus.smTaken = resp_accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      msm_valid_q <= 1'b0;
      msm_data_q  <= '0;
      msm_id_q    <= '0;
    end else if (resp_accept) begin
      msm_valid_q <= 1'b1;
      msm_data_q  <= bus.smData;
      msm_id_q    <= bus.smID;
    end else if (resp_drain) begin
      msm_valid_q <= 1'b0;
    end
  end

  assign bus.mSmValid = msm_valid_q;
  assign bus.mSmData  = msm_data_q;
  assign bus.mSmID    = msm_id_q;
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: arbitration order, request stall,
// response stall, back-to-back responses, async reset and concurrent traffic.
module tb_memory_bus_arbiter;
  localparam int NM = 4;
  localparam int DW = 24;
  localparam int AW = 32;
  localparam int IW = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  memory_bus_arbiter_if #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  memory_bus_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.mMsValid = '0;
    bus.mMsWrite = '0;
    bus.msTaken  = 1'b0;
    bus.smValid  = 1'b0;
    bus.smData   = '0;
    bus.smID     = '0;
    bus.mSmTaken = '0;
    for (int i = 0; i < NM; i++) begin
      bus.mMsID[i]      = IW'(i);
      bus.mMsAddress[i] = AW'(32'h1000 + i);
      bus.mMsData[i]    = DW'(24'h0A0000 + i);
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.mMsValid = 4'b1111;
    bus.smValid  = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b0 || bus.mSmValid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: msValid=%b mSmValid=%b required 0 0", bus.msValid, bus.mSmValid);
    end
    n_cmp++;
    if (bus.mMsTaken !== 4'b0000 || bus.smTaken !== 1'b0) begin
      n_err++; $display("FAIL reset_taken: mMsTaken=%b smTaken=%b required 0000 0", bus.mMsTaken, bus.smTaken);
    end
    n_cmp++;
    if (bus.msAddress !== '0 || bus.msData !== '0 || bus.msID !== '0 || bus.msWrite !== 1'b0 ||
        bus.mSmData !== '0 || bus.mSmID !== '0) begin
      n_err++; $display("FAIL reset_payload: addr=%h data=%h id=%h wr=%b smdata=%h smid=%h required all 0",
                        bus.msAddress, bus.msData, bus.msID, bus.msWrite, bus.mSmData, bus.mSmID);
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_taken;
    do_reset();
    bus.mMsValid = 4'b1111;
    bus.msTaken  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_taken = 4'b0001 << (k % NM);
      #1;
      n_cmp++;
      if (bus.mMsTaken !== exp_taken) begin
        n_err++; $display("FAIL rr_grant[%0d]: mMsTaken=%b required %b", k, bus.mMsTaken, exp_taken);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.msValid !== 1'b1 || bus.msID !== IW'(k % NM) || bus.msAddress !== AW'(32'h1000 + (k % NM))) begin
        n_err++; $display("FAIL rr_slot[%0d]: msValid=%b msID=%0d addr=%h required 1 %0d %h",
                          k, bus.msValid, bus.msID, bus.msAddress, k % NM, 32'h1000 + (k % NM));
      end
    end
  endtask

  task automatic test_request_stall();
    do_reset();
    bus.mMsValid[2]   = 1'b1;
    bus.mMsAddress[2] = 32'h100;
    bus.mMsData[2]    = 24'hABCDEF;
    bus.mMsWrite[2]   = 1'b1;
    bus.msTaken       = 1'b0;
    #1;
    n_cmp++;
    if (bus.mMsTaken !== 4'b0100) begin
      n_err++; $display("FAIL stall_grant: mMsTaken=%b required 0100", bus.mMsTaken);
    end
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      #1;
      bus.msTaken     = (k == 4);
      bus.mMsValid[2] = (k < 4);
      #1;
      n_cmp++;
      if (bus.msValid !== 1'b1 || bus.msAddress !== 32'h100 || bus.msData !== 24'hABCDEF ||
          bus.msWrite !== 1'b1 || bus.msID !== 4'd2) begin
        n_err++; $display("FAIL stall_hold[%0d]: v=%b addr=%h data=%h wr=%b id=%0d required 1 100 abcdef 1 2",
                          k, bus.msValid, bus.msAddress, bus.msData, bus.msWrite, bus.msID);
      end
      n_cmp++;
      if (bus.mMsTaken !== 4'b0000) begin
        n_err++; $display("FAIL stall_nogrant[%0d]: mMsTaken=%b required 0000", k, bus.mMsTaken);
      end
      @(posedge clk);
    end
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b0) begin
      n_err++; $display("FAIL stall_drain: msValid=%b required 0", bus.msValid);
    end
  endtask

  task automatic test_response_stall();
    do_reset();
    bus.smValid = 1'b1;
    bus.smID    = 4'd1;
    bus.smData  = 24'h123456;
    #1;
    n_cmp++;
    if (bus.smTaken !== 1'b1) begin
      n_err++; $display("FAIL rsp_accept: smTaken=%b required 1", bus.smTaken);
    end
    @(posedge clk);
    #1;
    bus.smID   = 4'd2;
    bus.smData = 24'h654321;
    for (int k = 1; k <= 3; k++) begin
      bus.mSmTaken = (k == 3) ? 4'b0010 : 4'b0000;
      #1;
      n_cmp++;
      if (bus.mSmValid !== 1'b1 || bus.mSmData !== 24'h123456 || bus.mSmID !== 4'd1) begin
        n_err++; $display("FAIL rsp_hold[%0d]: v=%b data=%h id=%0d required 1 123456 1",
                          k, bus.mSmValid, bus.mSmData, bus.mSmID);
      end
      n_cmp++;
      if (bus.smTaken !== (k == 3)) begin
        n_err++; $display("FAIL rsp_backpressure[%0d]: smTaken=%b required %b", k, bus.smTaken, (k == 3));
      end
      @(posedge clk);
      #1;
    end
    bus.smValid  = 1'b0;
    bus.mSmTaken = 4'b0000;
    #1;
    n_cmp++;
    if (bus.mSmValid !== 1'b1 || bus.mSmData !== 24'h654321 || bus.mSmID !== 4'd2) begin
      n_err++; $display("FAIL rsp_second: v=%b data=%h id=%0d required 1 654321 2",
                        bus.mSmValid, bus.mSmData, bus.mSmID);
    end
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] ids [0:2];
    logic [DW-1:0] dat [0:2];
    ids[0] = 4'd0; ids[1] = 4'd3; ids[2] = 4'd0;
    dat[0] = 24'h111111; dat[1] = 24'h333333; dat[2] = 24'h0F0F0F;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.smValid  = (k < 3);
      bus.smID     = (k < 3) ? ids[k] : '0;
      bus.smData   = (k < 3) ? dat[k] : '0;
      bus.mSmTaken = (k >= 1 && k <= 3) ? (4'b0001 << ids[k-1]) : 4'b0000;
      #1;
      n_cmp++;
      if (bus.smTaken !== (k < 3)) begin
        n_err++; $display("FAIL b2b_accept[%0d]: smTaken=%b required %b", k, bus.smTaken, (k < 3));
      end
      if (k >= 1 && k <= 3) begin
        n_cmp++;
        if (bus.mSmValid !== 1'b1 || bus.mSmID !== ids[k-1] || bus.mSmData !== dat[k-1]) begin
          n_err++; $display("FAIL b2b_deliver[%0d]: v=%b id=%0d data=%h required 1 %0d %h",
                            k, bus.mSmValid, bus.mSmID, bus.mSmData, ids[k-1], dat[k-1]);
        end
      end
      if (k == 4) begin
        n_cmp++;
        if (bus.mSmValid !== 1'b0) begin
          n_err++; $display("FAIL b2b_empty: mSmValid=%b required 0", bus.mSmValid);
        end
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.mMsValid[1] = 1'b1;
    bus.smValid     = 1'b1;
    bus.smID        = 4'd3;
    bus.smData      = 24'hBEEF00;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b1 || bus.mSmValid !== 1'b1) begin
      n_err++; $display("FAIL arst_setup: msValid=%b mSmValid=%b required 1 1", bus.msValid, bus.mSmValid);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b0 || bus.mSmValid !== 1'b0 || bus.msAddress !== '0 || bus.mSmData !== '0) begin
      n_err++; $display("FAIL arst_drop: msValid=%b mSmValid=%b addr=%h smdata=%h required 0 0 0 0",
                        bus.msValid, bus.mSmValid, bus.msAddress, bus.mSmData);
    end
    n_cmp++;
    if (bus.mMsTaken !== 4'b0000 || bus.smTaken !== 1'b0) begin
      n_err++; $display("FAIL arst_taken: mMsTaken=%b smTaken=%b required 0000 0", bus.mMsTaken, bus.smTaken);
    end
    @(posedge clk);
    #1;
    clear_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b0 || bus.mSmValid !== 1'b0) begin
      n_err++; $display("FAIL arst_noreplay: msValid=%b mSmValid=%b required 0 0", bus.msValid, bus.mSmValid);
    end
    bus.mMsValid = 4'b1001;
    bus.msTaken  = 1'b1;
    #1;
    n_cmp++;
    if (bus.mMsTaken !== 4'b0001) begin
      n_err++; $display("FAIL arst_first_grant: mMsTaken=%b required 0001", bus.mMsTaken);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b1 || bus.msID !== 4'd0) begin
      n_err++; $display("FAIL arst_first_slot: msValid=%b msID=%0d required 1 0", bus.msValid, bus.msID);
    end
    clear_inputs();
  endtask

  task automatic test_concurrent();
    do_reset();
    bus.mMsValid = 4'b0010;
    bus.msTaken  = 1'b1;
    bus.smValid  = 1'b1;
    bus.smID     = 4'd2;
    bus.smData   = 24'hC0FFEE;
    #1;
    n_cmp++;
    if (bus.mMsTaken !== 4'b0010 || bus.smTaken !== 1'b1) begin
      n_err++; $display("FAIL conc_c0: mMsTaken=%b smTaken=%b required 0010 1", bus.mMsTaken, bus.smTaken);
    end
    @(posedge clk);
    #1;
    bus.mMsValid = 4'b1000;
    bus.smID     = 4'd1;
    bus.smData   = 24'h00D00D;
    bus.mSmTaken = 4'b0100;
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b1 || bus.msID !== 4'd1 || bus.mSmValid !== 1'b1 ||
        bus.mSmID !== 4'd2 || bus.mSmData !== 24'hC0FFEE) begin
      n_err++; $display("FAIL conc_c1_out: msV=%b msID=%0d smV=%b smID=%0d smData=%h required 1 1 1 2 c0ffee",
                        bus.msValid, bus.msID, bus.mSmValid, bus.mSmID, bus.mSmData);
    end
    n_cmp++;
    if (bus.mMsTaken !== 4'b1000 || bus.smTaken !== 1'b1) begin
      n_err++; $display("FAIL conc_c1_taken: mMsTaken=%b smTaken=%b required 1000 1", bus.mMsTaken, bus.smTaken);
    end
    @(posedge clk);
    #1;
    bus.mMsValid = '0;
    bus.smValid  = 1'b0;
    bus.mSmTaken = 4'b0010;
    #1;
    n_cmp++;
    if (bus.msID !== 4'd3 || bus.msValid !== 1'b1 || bus.mSmID !== 4'd1 || bus.mSmData !== 24'h00D00D) begin
      n_err++; $display("FAIL conc_c2: msV=%b msID=%0d smID=%0d smData=%h required 1 3 1 00d00d",
                        bus.msValid, bus.msID, bus.mSmID, bus.mSmData);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.msValid !== 1'b0 || bus.mSmValid !== 1'b0) begin
      n_err++; $display("FAIL conc_idle: msValid=%b mSmValid=%b required 0 0", bus.msValid, bus.mSmValid);
    end
    clear_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_request_stall();
    test_response_stall();
    test_back_to_back();
    test_async_reset();
    test_concurrent();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of bus masters (ray memory units etc.) sharing one memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 24, bus data width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 32, bus address width.
REQ-004 SHALL have parameter ID_WIDTH, default 4, master ID width; master i uses ID i.
REQ-005 SHALL have ports: clock in 1, sole clock; reset in 1, asynchronous active-high.
REQ-006 SHALL have master request ports: mMsValid in [NUM_MASTERS], mMsTaken out [NUM_MASTERS], mMsAddress in [NUM_MASTERS]xADDRESS_WIDTH, mMsData in [NUM_MASTERS]xDATA_WIDTH, mMsWrite in [NUM_MASTERS], mMsID in [NUM_MASTERS]xID_WIDTH.
REQ-007 SHALL have memory request ports: msValid out 1, msTaken in 1, msAddress out ADDRESS_WIDTH, msData out DATA_WIDTH, msWrite out 1, msID out ID_WIDTH.
REQ-008 SHALL have memory response ports: smValid in 1, smTaken out 1, smData in DATA_WIDTH, smID in ID_WIDTH.
REQ-009 SHALL have master response ports: mSmValid out 1, mSmData out DATA_WIDTH, mSmID out ID_WIDTH (broadcast to all masters), mSmTaken in [NUM_MASTERS].

Function
REQ-010 Request path SHALL hold one registered output slot (valid, address, data, write, ID).
REQ-011 Slot SHALL be loadable in a cycle when empty or draining (msValid && msTaken).
REQ-012 When loadable, arbiter SHALL grant exactly one requesting master, round-robin, searching from lastGrant+1 modulo NUM_MASTERS.
REQ-013 Grant SHALL assert mMsTaken[g] combinationally in that cycle only; all other mMsTaken low.
REQ-014 Granted request SHALL appear on msValid/ms* the following clock edge (1-cycle latency); lastGrant updates to g at that edge.
REQ-015 If loadable and no master valid, slot SHALL clear (if draining) or stay empty; lastGrant unchanged.
REQ-016 msValid SHALL remain high with ms* stable until msTaken; full throughput of one request per cycle when msTaken held high.
REQ-017 msID SHALL be mMsID of granted master, passed unmodified.
REQ-018 Response path SHALL hold one registered buffer (valid, data, ID) driving mSmValid/mSmData/mSmID.
REQ-019 smTaken SHALL equal smValid && (buffer empty || buffer drained this cycle), combinational.
REQ-020 Buffer drains when mSmValid && any mSmTaken bit high; accepted response appears next edge; simultaneous drain and accept SHALL give back-to-back delivery.
REQ-021 Buffer SHALL hold a response not taken by any master indefinitely (stall); more than one mSmTaken high is illegal input, treated as single drain.
REQ-022 Writes (msWrite=1) SHALL expect no response; arbiter SHALL not track outstanding transactions.
REQ-023 Request and response paths SHALL operate independently in the same cycle.

Reset
REQ-024 On reset assertion, asynchronously: msValid=0, mSmValid=0, lastGrant=NUM_MASTERS-1, ms*/mSm* data/address/ID=0, msWrite=0.
REQ-025 During reset, mMsTaken and smTaken SHALL be 0.
REQ-026 Reset mid-transfer SHALL discard slot and buffer contents; no replay after release.
REQ-027 First grant after reset SHALL favour master 0 when multiple requests present.

Verification
REQ-028 All 4 masters valid, msTaken=1 constant, after reset -> grants 0,1,2,3,0 on consecutive cycles; msID follows 0,1,2,3,0.
REQ-029 Master 2 valid only, address 0x100, data 0xABCDEF, write=1, msTaken=0 for 3 cycles then 1 -> mMsTaken[2] one cycle; msValid high 4 cycles with address 0x100 stable; no second grant until drain.
REQ-030 smValid=1, smID=1, smData=0x123456, masters' mSmTaken low 2 cycles then mSmTaken[1]=1 -> smTaken 1 cycle, mSmValid held 3 cycles with data 0x123456, second memory response held off (smTaken=0) until drain.
REQ-031 Continuous responses IDs 0,3,0 with mSmTaken always matching -> one response per cycle, order preserved.
REQ-032 Reset asserted mid-cycle while msValid=1 and mSmValid=1 -> both drop immediately without clock edge; after release master 0 wins over master 3.
REQ-033 Concurrent request grant and response delivery in same cycle -> both complete; no interference on either path.
